// File: rtl/muonic_mux_pkg.sv
// Shared types and constants for the N-to-1 muonic time-multiplexer.
package muonic_mux_pkg;

  localparam int unsigned ERR_CNT_W   = 8;
  localparam int unsigned ERR_CNT_MAX = 255;
  localparam int unsigned NSLOTS_MIN  = 2;
  localparam int unsigned NSLOTS_MAX  = 8;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } sync_state_e;

  // True when the slot count is supported and the slot counters are wide enough to hold it.
  function automatic bit slot_w_ok(input int unsigned nslots, input int unsigned slot_w);
    int unsigned need;
    need = int'($clog2(nslots));
    return (nslots >= NSLOTS_MIN) && (nslots <= NSLOTS_MAX) && (slot_w >= need);
  endfunction

endpackage

// File: rtl/x_mux_frame_sync.sv
// Frame alignment tracker: phase counter, lock FSM, alignment-error pulse and saturating error count.
module x_mux_frame_sync
  import muonic_mux_pkg::*;
#(
  parameter int unsigned NSLOTS = 2,
  parameter int unsigned SLOT_W = 3
) (
  input  logic              clock,
  input  logic              clr_n,
  input  logic              sclr,
  input  logic              frame,
  output logic [SLOT_W-1:0] ph,
  output logic              locked,
  output logic              accept,
  output logic              frame_err,
  output logic [7:0]        err_cnt
);

  sync_state_e          state_q;
  sync_state_e          state_d;
  logic [SLOT_W-1:0]    ph_q;
  logic [SLOT_W-1:0]    ph_d;
  logic [SLOT_W-1:0]    ph_inc;
  logic                 frame_err_q;
  logic                 err_evt;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic [ERR_CNT_W-1:0] err_cnt_d;

  // Every strobe (normal or misplaced) reloads the capture register unless a clear wins.
  assign accept = frame & ~sclr;

  // Phase successor, wrapping at the frame length.
  always_comb begin
    ph_inc = ph_q + SLOT_W'(1);
    if (ph_q == SLOT_W'(NSLOTS - 1)) begin
      ph_inc = '0;
    end
  end

  // Lock FSM next state, phase and error event.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    err_evt = 1'b0;
    if (sclr) begin
      state_d = ST_UNLOCKED;
      ph_d    = '0;
    end else begin
      case (state_q)
        ST_UNLOCKED: begin
          if (frame) begin
            state_d = ST_LOCKED;
            ph_d    = SLOT_W'(1);
          end
        end
        ST_LOCKED: begin
          ph_d = ph_inc;
          if (frame) begin
            // A strobe off phase 0 realigns the phase to the new strobe.
            err_evt = (ph_q != '0);
            ph_d    = SLOT_W'(1);
          end else if (ph_q == '0) begin
            // Expected strobe is absent: drop lock and abandon the frame.
            err_evt = 1'b1;
            state_d = ST_UNLOCKED;
            ph_d    = '0;
          end
        end
        default: begin
          state_d = ST_UNLOCKED;
          ph_d    = '0;
        end
      endcase
    end
  end

  // Saturating error counter; only the asynchronous reset clears it.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_evt && (err_cnt_q != ERR_CNT_W'(ERR_CNT_MAX))) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  // State, phase and error registers.
  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= ST_UNLOCKED;
      ph_q        <= '0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      frame_err_q <= err_evt;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign ph        = ph_q;
  assign locked    = (state_q == ST_LOCKED);
  assign frame_err = frame_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: rtl/x_mux_nto1_muonic.sv
// N-to-1 time-multiplexer: serialises a parallel frame onto one word per commutator clock,
// with programmable slot offset, order reversal, alignment checking and idle blanking.
module x_mux_nto1_muonic
  import muonic_mux_pkg::*;
#(
  parameter int unsigned      WIDTH    = 8,
  parameter int unsigned      NSLOTS   = 2,
  parameter int unsigned      SLOT_W   = 3,
  parameter logic [WIDTH-1:0] IDLE_PAT = '0
) (
  input  logic                    clock,
  input  logic                    clr_n,
  input  logic                    sclr,
  input  logic                    frame,
  input  logic [NSLOTS*WIDTH-1:0] din,
  input  logic [SLOT_W-1:0]       slot_offset,
  input  logic                    reverse,
  output logic [WIDTH-1:0]        dout,
  output logic                    dout_first,
  output logic                    locked,
  output logic                    frame_err,
  output logic [7:0]              err_cnt
);

  localparam int unsigned FW = NSLOTS * WIDTH;
  localparam int unsigned EW = SLOT_W + 1;

  if (!slot_w_ok(NSLOTS, SLOT_W)) begin : g_param_check
    $error("x_mux_nto1_muonic: NSLOTS must be 2..8 and SLOT_W >= clog2(NSLOTS)");
  end

  logic [SLOT_W-1:0] ph;
  logic              accept;
  logic              sync_locked;
  logic [FW-1:0]     a_q;
  logic [FW-1:0]     a_d;
  logic [FW-1:0]     b_q;
  logic [FW-1:0]     b_d;
  logic [SLOT_W-1:0] off_q;
  logic [SLOT_W-1:0] off_d;
  logic [SLOT_W-1:0] off_in;
  logic              rev_q;
  logic              rev_d;
  logic [WIDTH-1:0]  dout_q;
  logic [WIDTH-1:0]  dout_d;
  logic              first_q;
  logic              first_d;
  logic [EW-1:0]     e_raw;
  logic [SLOT_W-1:0] e;

  // Word k of a frame, counted from the far end when reversed.
  function automatic logic [WIDTH-1:0] pick_word(input logic [FW-1:0]     x,
                                                 input logic [SLOT_W-1:0] k,
                                                 input logic              rev);
    logic [SLOT_W-1:0] idx;
    logic [WIDTH-1:0]  w;
    idx = rev ? (SLOT_W'(NSLOTS - 1) - k) : k;
    w   = '0;
    for (int i = 0; i < int'(NSLOTS); i++) begin
      if (idx == SLOT_W'(i)) begin
        w = x[i*WIDTH +: WIDTH];
      end
    end
    return w;
  endfunction

  x_mux_frame_sync #(
    .NSLOTS (NSLOTS),
    .SLOT_W (SLOT_W)
  ) u_frame_sync (
    .clock     (clock),
    .clr_n     (clr_n),
    .sclr      (sclr),
    .frame     (frame),
    .ph        (ph),
    .locked    (sync_locked),
    .accept    (accept),
    .frame_err (frame_err),
    .err_cnt   (err_cnt)
  );

  // Out-of-range offsets saturate to the last slot.
  always_comb begin
    off_in = slot_offset;
    if (slot_offset > SLOT_W'(NSLOTS - 1)) begin
      off_in = SLOT_W'(NSLOTS - 1);
    end
  end

  // Emission index (ph - 1 - off) mod NSLOTS, biased positive in one extra bit.
  always_comb begin
    e_raw = EW'(ph) + EW'(NSLOTS - 1) - EW'(off_q);
    if (e_raw >= EW'(NSLOTS)) begin
      e_raw = e_raw - EW'(NSLOTS);
    end
    e = SLOT_W'(e_raw);
  end

  // Capture register A and the per-frame offset/reverse settings.
  always_comb begin
    a_d   = a_q;
    off_d = off_q;
    rev_d = rev_q;
    if (sclr) begin
      a_d   = '0;
      off_d = '0;
      rev_d = 1'b0;
    end else if (accept) begin
      a_d   = din;
      off_d = off_in;
      rev_d = reverse;
    end
  end

  // Output word select; slot 0 comes straight from A while A is handed to B.
  always_comb begin
    b_d     = b_q;
    dout_d  = IDLE_PAT;
    first_d = 1'b0;
    if (sclr) begin
      b_d = '0;
    end else if (sync_locked) begin
      if (e == '0) begin
        b_d     = a_q;
        dout_d  = pick_word(a_q, '0, rev_q);
        first_d = 1'b1;
      end else begin
        dout_d = pick_word(b_q, e, rev_q);
      end
    end
  end

  // Frame buffers, settings and output registers.
  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      a_q     <= '0;
      b_q     <= '0;
      off_q   <= '0;
      rev_q   <= 1'b0;
      dout_q  <= IDLE_PAT;
      first_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      off_q   <= off_d;
      rev_q   <= rev_d;
      dout_q  <= dout_d;
      first_q <= first_d;
    end
  end

  assign dout       = dout_q;
  assign dout_first = first_q;
  assign locked     = sync_locked;

endmodule

// File: tb/tb_x_mux_nto1_muonic.sv
// Self-checking bench for x_mux_nto1_muonic (NSLOTS=4, WIDTH=8, IDLE_PAT=A5).
module tb_x_mux_nto1_muonic;

  localparam int         N    = 4;
  localparam int         W    = 8;
  localparam int         SW   = 3;
  localparam logic [7:0] IDLE = 8'hA5;
  localparam int         MAXC = 8192;

  logic          clock = 1'b0;
  logic          clr_n;
  logic          sclr;
  logic          frame;
  logic [31:0]   din;
  logic [SW-1:0] slot_offset;
  logic          reverse;
  logic [W-1:0]  dout;
  logic          dout_first;
  logic          locked;
  logic          frame_err;
  logic [7:0]    err_cnt;

  always #5 clock = ~clock;

  x_mux_nto1_muonic #(
    .WIDTH    (W),
    .NSLOTS   (N),
    .SLOT_W   (SW),
    .IDLE_PAT (IDLE)
  ) dut (
    .clock       (clock),
    .clr_n       (clr_n),
    .sclr        (sclr),
    .frame       (frame),
    .din         (din),
    .slot_offset (slot_offset),
    .reverse     (reverse),
    .dout        (dout),
    .dout_first  (dout_first),
    .locked      (locked),
    .frame_err   (frame_err),
    .err_cnt     (err_cnt)
  );

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  // Reference model: expected output schedule indexed by cycle, plus lock/error bookkeeping.
  bit         sv [MAXC];
  logic [7:0] sd [MAXC];
  bit         sf [MAXC];
  bit         m_lk  = 1'b0;
  int         m_last = 0;
  int         m_cnt  = 0;

  logic [7:0] e_dout;
  bit         e_dknown;
  bit         e_first;
  bit         e_lk;
  bit         e_err;
  int         e_cnt;

  function automatic logic [7:0] slot_of(input logic [31:0] d, input int k, input bit rev);
    int j;
    j = rev ? (N - 1 - k) : k;
    return d[j*8 +: 8];
  endfunction

  task automatic drop_from(input int c);
    for (int i = c; i < c + 16 && i < MAXC; i++) sv[i] = 1'b0;
  endtask

  task automatic sched_frame(input int c, input logic [31:0] d, input int off, input bit rev);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = c + 2 + off + k;
      if (idx < MAXC) begin
        sv[idx] = 1'b1;
        sd[idx] = slot_of(d, k, rev);
        sf[idx] = (k == 0);
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model, then move to the next sample point.
  task automatic tick(input bit fr, input logic [31:0] d, input int off, input bit rv, input bit sc);
    bit idle;
    int ph;
    frame = fr; din = d; slot_offset = SW'(off); reverse = rv; sclr = sc;
    idle  = sc || !m_lk;
    e_err = 1'b0;
    if (sc) begin
      m_lk = 1'b0;
      drop_from(cyc + 1);
    end else if (!m_lk) begin
      if (fr) begin
        m_lk = 1'b1; m_last = cyc; sched_frame(cyc, d, off, rv);
      end
    end else begin
      ph = (cyc - m_last) % N;
      if (fr) begin
        if (ph != 0) begin e_err = 1'b1; drop_from(cyc + 2); end
        m_last = cyc; sched_frame(cyc, d, off, rv);
      end else if (ph == 0) begin
        e_err = 1'b1; m_lk = 1'b0; drop_from(cyc + 2);
      end
    end
    if (e_err && m_cnt < 255) m_cnt++;
    e_lk  = m_lk;
    e_cnt = m_cnt;
    if (idle) begin
      e_dknown = 1'b1; e_dout = IDLE; e_first = 1'b0;
    end else if (cyc + 1 < MAXC && sv[cyc + 1]) begin
      e_dknown = 1'b1; e_dout = sd[cyc + 1]; e_first = sf[cyc + 1];
    end else begin
      e_dknown = 1'b0; e_dout = 8'h00; e_first = 1'b0;
    end
    cyc++;
    @(negedge clock);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    nchk++; if (dout !== IDLE)       begin nerr++; $display("FAIL reset_dout: got %h expected %h", dout, IDLE); end
    nchk++; if (dout_first !== 1'b0) begin nerr++; $display("FAIL reset_first: got %b expected 0", dout_first); end
    nchk++; if (locked !== 1'b0)     begin nerr++; $display("FAIL reset_locked: got %b expected 0", locked); end
    nchk++; if (frame_err !== 1'b0)  begin nerr++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    nchk++; if (err_cnt !== 8'd0)    begin nerr++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
    clr_n = 1'b1;
  endtask

  task automatic test_basic_order();
    for (int f = 0; f < 5; f++) begin
      for (int p = 0; p < N; p++) begin
        tick(p == 0, 32'h44332211, 0, 1'b0, 1'b0);
        nchk++; if (locked !== e_lk) begin nerr++; $display("FAIL basic_locked cyc %0d: got %b expected %b", cyc, locked, e_lk); end
        nchk++; if (dout_first !== e_first) begin nerr++; $display("FAIL basic_first cyc %0d: got %b expected %b", cyc, dout_first, e_first); end
        if (e_dknown) begin
          nchk++; if (dout !== e_dout) begin nerr++; $display("FAIL basic_dout cyc %0d: got %h expected %h", cyc, dout, e_dout); end
        end
        if (dout_first === 1'b1) begin
          nchk++; if (dout !== 8'h11) begin nerr++; $display("FAIL basic_first_word: got %h expected 11", dout); end
        end
      end
    end
  endtask

  task automatic test_offset_reverse();
    tick(1'b0, 32'h0, 0, 1'b0, 1'b1);
    nchk++; if (dout !== IDLE)   begin nerr++; $display("FAIL offrev_sclr_dout: got %h expected %h", dout, IDLE); end
    nchk++; if (locked !== 1'b0) begin nerr++; $display("FAIL offrev_sclr_locked: got %b expected 0", locked); end
    for (int f = 0; f < 5; f++) begin
      for (int p = 0; p < N; p++) begin
        // Offset/reverse pins wander mid-frame but are correct at every strobe.
        if (p == 0) tick(1'b1, 32'h44332211, 2, 1'b1, 1'b0);
        else        tick(1'b0, 32'h44332211, p - 1, p[0], 1'b0);
        nchk++; if (dout_first !== e_first) begin nerr++; $display("FAIL offrev_first cyc %0d: got %b expected %b", cyc, dout_first, e_first); end
        if (e_dknown) begin
          nchk++; if (dout !== e_dout) begin nerr++; $display("FAIL offrev_dout cyc %0d: got %h expected %h", cyc, dout, e_dout); end
        end
        if (dout_first === 1'b1) begin
          nchk++; if (dout !== 8'h44) begin nerr++; $display("FAIL offrev_first_word: got %h expected 44", dout); end
        end
      end
    end
  endtask

  task automatic test_missing_frame();
    tick(1'b0, 32'h0, 0, 1'b0, 1'b1);
    for (int f = 0; f < 7; f++) begin
      for (int p = 0; p < N; p++) begin
        tick((p == 0) && (f != 3), (f + 1) * 32'h01010101, 0, 1'b0, 1'b0);
        nchk++; if (frame_err !== e_err) begin nerr++; $display("FAIL miss_frame_err cyc %0d: got %b expected %b", cyc, frame_err, e_err); end
        nchk++; if (err_cnt !== 8'(e_cnt)) begin nerr++; $display("FAIL miss_err_cnt cyc %0d: got %0d expected %0d", cyc, err_cnt, e_cnt); end
        nchk++; if (locked !== e_lk) begin nerr++; $display("FAIL miss_locked cyc %0d: got %b expected %b", cyc, locked, e_lk); end
        if (e_dknown) begin
          nchk++; if (dout !== e_dout) begin nerr++; $display("FAIL miss_dout cyc %0d: got %h expected %h", cyc, dout, e_dout); end
        end
      end
    end
  endtask

  task automatic test_misplaced_frame();
    int gap [6] = '{4, 4, 3, 4, 4, 4};
    tick(1'b0, 32'h0, 0, 1'b0, 1'b1);
    for (int f = 0; f < 6; f++) begin
      for (int p = 0; p < gap[f]; p++) begin
        tick(p == 0, 32'hD0C0B0A0 + 32'(f), 0, 1'b0, 1'b0);
        nchk++; if (frame_err !== e_err) begin nerr++; $display("FAIL misp_frame_err cyc %0d: got %b expected %b", cyc, frame_err, e_err); end
        nchk++; if (err_cnt !== 8'(e_cnt)) begin nerr++; $display("FAIL misp_err_cnt cyc %0d: got %0d expected %0d", cyc, err_cnt, e_cnt); end
        nchk++; if (locked !== e_lk) begin nerr++; $display("FAIL misp_locked cyc %0d: got %b expected %b", cyc, locked, e_lk); end
        nchk++; if (dout_first !== e_first) begin nerr++; $display("FAIL misp_first cyc %0d: got %b expected %b", cyc, dout_first, e_first); end
        if (e_dknown) begin
          nchk++; if (dout !== e_dout) begin nerr++; $display("FAIL misp_dout cyc %0d: got %h expected %h", cyc, dout, e_dout); end
        end
      end
    end
  endtask

  task automatic test_random_stream();
    for (int seg = 0; seg < 3; seg++) begin
      int          off;
      bit          rv;
      int          p;
      logic [31:0] d;
      off = int'($urandom_range(0, N - 1));
      rv  = 1'($urandom_range(0, 1));
      p   = 0;
      d   = $urandom;
      tick(1'b0, d, 0, 1'b0, 1'b1);
      for (int i = 0; i < 400; i++) begin
        bit fr;
        bit sc;
        fr = (p == 0);
        if ($urandom_range(0, 99) < 3) fr = !fr;
        sc = ($urandom_range(0, 199) == 0);
        if (fr) begin
          d = $urandom;
          tick(1'b1, d, off, rv, sc);
        end else begin
          tick(1'b0, $urandom, int'($urandom_range(0, N - 1)), 1'($urandom_range(0, 1)), sc);
        end
        p = (p + 1) % N;
        nchk++; if (locked !== e_lk) begin nerr++; $display("FAIL rnd_locked cyc %0d: got %b expected %b", cyc, locked, e_lk); end
        nchk++; if (frame_err !== e_err) begin nerr++; $display("FAIL rnd_frame_err cyc %0d: got %b expected %b", cyc, frame_err, e_err); end
        nchk++; if (err_cnt !== 8'(e_cnt)) begin nerr++; $display("FAIL rnd_err_cnt cyc %0d: got %0d expected %0d", cyc, err_cnt, e_cnt); end
        nchk++; if (dout_first !== e_first) begin nerr++; $display("FAIL rnd_first cyc %0d: got %b expected %b", cyc, dout_first, e_first); end
        if (e_dknown) begin
          nchk++; if (dout !== e_dout) begin nerr++; $display("FAIL rnd_dout cyc %0d: got %h expected %h", cyc, dout, e_dout); end
        end
      end
    end
  endtask

  task automatic test_err_saturation();
    tick(1'b0, 32'h0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 310; i++) begin
      tick(1'b1, $urandom, 0, 1'b0, 1'b0);
      nchk++; if (err_cnt !== 8'(e_cnt)) begin nerr++; $display("FAIL sat_err_cnt cyc %0d: got %0d expected %0d", cyc, err_cnt, e_cnt); end
      if (e_dknown) begin
        nchk++; if (dout !== e_dout) begin nerr++; $display("FAIL sat_dout cyc %0d: got %h expected %h", cyc, dout, e_dout); end
      end
    end
    nchk++; if (err_cnt !== 8'd255) begin nerr++; $display("FAIL sat_final: got %0d expected 255", err_cnt); end
    tick(1'b0, 32'h0, 0, 1'b0, 1'b1);
    nchk++; if (err_cnt !== 8'd255) begin nerr++; $display("FAIL sat_held_by_sclr: got %0d expected 255", err_cnt); end
    nchk++; if (locked !== 1'b0)    begin nerr++; $display("FAIL sat_sclr_locked: got %b expected 0", locked); end
    nchk++; if (dout !== IDLE)      begin nerr++; $display("FAIL sat_sclr_dout: got %h expected %h", dout, IDLE); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 6; i++) tick(i % N == 0, 32'h87654321, 1, 1'b0, 1'b0);
    nchk++; if (locked !== 1'b1) begin nerr++; $display("FAIL areset_pre_locked: got %b expected 1", locked); end
    #2 clr_n = 1'b0;
    #1;
    nchk++; if (dout !== IDLE)       begin nerr++; $display("FAIL areset_dout: got %h expected %h", dout, IDLE); end
    nchk++; if (dout_first !== 1'b0) begin nerr++; $display("FAIL areset_first: got %b expected 0", dout_first); end
    nchk++; if (locked !== 1'b0)     begin nerr++; $display("FAIL areset_locked: got %b expected 0", locked); end
    nchk++; if (frame_err !== 1'b0)  begin nerr++; $display("FAIL areset_frame_err: got %b expected 0", frame_err); end
    nchk++; if (err_cnt !== 8'd0)    begin nerr++; $display("FAIL areset_err_cnt: got %0d expected 0", err_cnt); end
    m_lk = 1'b0; m_cnt = 0; drop_from(cyc);
    @(negedge clock);
    clr_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(i == 2, 32'h0F1E2D3C, 0, 1'b1, 1'b0);
      nchk++; if (locked !== e_lk) begin nerr++; $display("FAIL areset_relock cyc %0d: got %b expected %b", cyc, locked, e_lk); end
      if (e_dknown) begin
        nchk++; if (dout !== e_dout) begin nerr++; $display("FAIL areset_dout_after cyc %0d: got %h expected %h", cyc, dout, e_dout); end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_n = 1'b0; sclr = 1'b0; frame = 1'b0; din = '0; slot_offset = '0; reverse = 1'b0;
    test_reset();
    test_basic_order();
    test_offset_reverse();
    test_missing_frame();
    test_misplaced_frame();
    test_random_stream();
    test_err_saturation();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
